// File: rtl/sha256_pkg.sv
// Shared SHA-256 definitions: widths, FSM encoding, round constants and the
// message-schedule sigma functions used by both the scheduler and round stage.
package sha256_pkg;

    localparam int WORD_W = 32;
    localparam int BLK_W  = 512;
    localparam int ROUNDS = 64;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [WORD_W-1:0] K_TABLE [ROUNDS] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    function automatic logic [WORD_W-1:0] k_const(input logic [5:0] t);
        return K_TABLE[t];
    endfunction

    // sig0 = ROTR7 ^ ROTR18 ^ SHR3
    function automatic logic [WORD_W-1:0] sig0(input logic [WORD_W-1:0] x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
    endfunction

    // sig1 = ROTR17 ^ ROTR19 ^ SHR10
    function automatic logic [WORD_W-1:0] sig1(input logic [WORD_W-1:0] x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
    endfunction

endpackage

// File: rtl/sha256_k_rom.sv
// Round-constant lookup: 6-bit round index to 32-bit K[t], purely combinational.
module sha256_k_rom
    import sha256_pkg::*;
(
    input  logic [5:0]        addr_i,
    output logic [WORD_W-1:0] k_o
);

    assign k_o = k_const(addr_i);

endmodule

// File: rtl/sha256_msg_sched.sv
// SHA-256 message scheduler: accepts a 512-bit block and streams W[t]/K[t]
// for t = 0..63 under a ready/valid handshake, using a 16-word sliding window.
module sha256_msg_sched
    import sha256_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [BLK_W-1:0]  blk_data_i,
    input  logic              blk_valid_i,
    output logic              blk_ready_o,
    output logic [WORD_W-1:0] w_out_o,
    output logic [WORD_W-1:0] k_out_o,
    output logic [5:0]        t_out_o,
    output logic              w_last_o,
    output logic              w_valid_o,
    input  logic              w_ready_i
);

    state_t            state_q, state_d;
    logic [5:0]        t_q, t_d;
    logic [WORD_W-1:0] win_q [16];
    logic [WORD_W-1:0] win_d [16];
    logic              blk_ready_q, blk_ready_d;
    logic              w_valid_q, w_valid_d;
    logic [WORD_W-1:0] new_word;
    logic [WORD_W-1:0] k_lookup;
    logic              blk_accept;
    logic              round_fire;

    sha256_k_rom u_k_rom (
        .addr_i (t_q),
        .k_o    (k_lookup)
    );

    // Word consumed now is win[0]; win[15] is refilled 16 rounds ahead of use.
    assign new_word   = sig1(win_q[14]) + win_q[9] + sig0(win_q[1]) + win_q[0];
    assign blk_accept = blk_valid_i & blk_ready_q;
    assign round_fire = w_valid_q & w_ready_i;

    always_comb begin
        state_d     = state_q;
        t_d         = t_q;
        blk_ready_d = blk_ready_q;
        w_valid_d   = w_valid_q;
        for (int i = 0; i < 16; i++) begin
            win_d[i] = win_q[i];
        end

        case (state_q)
            IDLE: begin
                if (blk_accept) begin
                    for (int i = 0; i < 16; i++) begin
                        win_d[i] = blk_data_i[BLK_W-1-WORD_W*i -: WORD_W];
                    end
                    t_d         = '0;
                    state_d     = RUN;
                    blk_ready_d = 1'b0;
                    w_valid_d   = 1'b1;
                end
            end
            RUN: begin
                if (round_fire) begin
                    for (int i = 0; i < 15; i++) begin
                        win_d[i] = win_q[i+1];
                    end
                    win_d[15] = new_word;
                    t_d       = t_q + 6'd1;
                    // Last round: drop back to IDLE; the wrap of t brings it to 0.
                    if (t_q == 6'(ROUNDS - 1)) begin
                        state_d     = IDLE;
                        blk_ready_d = 1'b1;
                        w_valid_d   = 1'b0;
                    end
                end
            end
            default: begin
                state_d     = IDLE;
                blk_ready_d = 1'b1;
                w_valid_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            t_q         <= '0;
            blk_ready_q <= 1'b1;
            w_valid_q   <= 1'b0;
            for (int i = 0; i < 16; i++) begin
                win_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            t_q         <= t_d;
            blk_ready_q <= blk_ready_d;
            w_valid_q   <= w_valid_d;
            for (int i = 0; i < 16; i++) begin
                win_q[i] <= win_d[i];
            end
        end
    end

    // Data outputs are forced to zero while reset is held.
    assign blk_ready_o = blk_ready_q;
    assign w_valid_o   = w_valid_q;
    assign w_out_o     = rst_i ? '0 : win_q[0];
    assign k_out_o     = rst_i ? '0 : k_lookup;
    assign t_out_o     = rst_i ? '0 : t_q;
    assign w_last_o    = (t_out_o == 6'(ROUNDS - 1));

endmodule
